// File: rtl/mips_execute_decode.sv
// Combined decode/execute stage: main control, ALU control and 32-bit ALU feeding a registered EX/MEM bundle.
// Optional signed-overflow detection is enabled by defining ALU_OVERFLOW_EN.
module mips_execute_decode (
    input  logic        system_clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] instruction,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        out_valid,
    output logic [31:0] alu_result,
    output logic        zero_output,
    output logic        overflow,
    output logic [31:0] store_data,
    output logic [4:0]  write_address,
    output logic        register_write,
    output logic        memory_read,
    output logic        memory_write,
    output logic        memory_to_register,
    output logic        branch_eq,
    output logic        branch_ne,
    output logic        jump
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_t;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [4:0]  rt_field;
    logic [4:0]  rd_field;
    logic        unused_rs_field;

    assign opcode          = instruction[31:26];
    assign rt_field        = instruction[20:16];
    assign rd_field        = instruction[15:11];
    assign funct           = instruction[5:0];
    assign imm             = instruction[15:0];
    // rs arrives already resolved through rs_data.
    assign unused_rs_field = ^instruction[25:21];

    logic       reg_dst, alu_src, zero_ext, shift_upper;
    logic [1:0] alu_op;
    logic       dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg;
    logic       dec_branch_eq, dec_branch_ne, dec_jump;

    always_comb begin
        reg_dst        = 1'b0;
        alu_src        = 1'b0;
        zero_ext       = 1'b0;
        shift_upper    = 1'b0;
        alu_op         = 2'b00;
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_branch_eq  = 1'b0;
        dec_branch_ne  = 1'b0;
        dec_jump       = 1'b0;
        case (opcode)
            OP_RTYPE: begin reg_dst = 1'b1; dec_reg_write = 1'b1; alu_op = 2'b10; end
            OP_LW: begin
                alu_src = 1'b1; dec_mem_read = 1'b1; dec_mem_to_reg = 1'b1; dec_reg_write = 1'b1;
            end
            OP_SW:   begin alu_src = 1'b1; dec_mem_write = 1'b1; end
            OP_BEQ:  begin dec_branch_eq = 1'b1; alu_op = 2'b01; end
            OP_BNE:  begin dec_branch_ne = 1'b1; alu_op = 2'b01; end
            OP_ADDI: begin alu_src = 1'b1; dec_reg_write = 1'b1; end
            OP_ORI:  begin alu_src = 1'b1; zero_ext = 1'b1; dec_reg_write = 1'b1; alu_op = 2'b11; end
            OP_LUI:  begin shift_upper = 1'b1; dec_reg_write = 1'b1; end
            OP_J:    dec_jump = 1'b1;
            default: ;
        endcase
    end

    alu_ctrl_t alu_ctrl;

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            2'b01: alu_ctrl = ALU_SUB;
            2'b11: alu_ctrl = ALU_OR;
            2'b10: begin
                case (funct)
                    6'b100010, 6'b100011: alu_ctrl = ALU_SUB;
                    6'b100100:            alu_ctrl = ALU_AND;
                    6'b100101:            alu_ctrl = ALU_OR;
                    6'b100111:            alu_ctrl = ALU_NOR;
                    6'b101010:            alu_ctrl = ALU_SLT;
                    default:              alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    logic [31:0] operand_a, operand_b, imm_ext, alu_value, final_result;

    assign operand_a = rs_data;
    assign imm_ext   = zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    assign operand_b = alu_src ? imm_ext : rt_data;

    always_comb begin
        alu_value = 32'h0;
        case (alu_ctrl)
            ALU_ADD: alu_value = operand_a + operand_b;
            ALU_SUB: alu_value = operand_a - operand_b;
            ALU_AND: alu_value = operand_a & operand_b;
            ALU_OR:  alu_value = operand_a | operand_b;
            ALU_NOR: alu_value = ~(operand_a | operand_b);
            ALU_SLT: alu_value = {31'h0, $signed(operand_a) < $signed(operand_b)};
            default: alu_value = 32'h0;
        endcase
    end

    assign final_result = shift_upper ? {imm, 16'h0000} : alu_value;

    logic ovf_next;
`ifdef ALU_OVERFLOW_EN
    logic ovf_checked;
    // Only the trapping forms (add, sub, addi) report overflow; addu/subu and address math never do.
    assign ovf_checked = (opcode == OP_ADDI) ||
                         ((opcode == OP_RTYPE) && ((funct == 6'b100000) || (funct == 6'b100010)));
    always_comb begin
        ovf_next = 1'b0;
        if (ovf_checked) begin
            if (alu_ctrl == ALU_ADD)
                ovf_next = (operand_a[31] == operand_b[31]) && (final_result[31] != operand_a[31]);
            else if (alu_ctrl == ALU_SUB)
                ovf_next = (operand_a[31] != operand_b[31]) && (final_result[31] != operand_a[31]);
        end
    end
`else
    assign ovf_next = 1'b0;
`endif

    // Control strobes are squashed on bubbles so downstream stages never act on stale decode.
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            out_valid          <= 1'b0;
            alu_result         <= 32'h0;
            zero_output        <= 1'b0;
            overflow           <= 1'b0;
            store_data         <= 32'h0;
            write_address      <= 5'h0;
            register_write     <= 1'b0;
            memory_read        <= 1'b0;
            memory_write       <= 1'b0;
            memory_to_register <= 1'b0;
            branch_eq          <= 1'b0;
            branch_ne          <= 1'b0;
            jump               <= 1'b0;
        end else begin
            out_valid          <= in_valid;
            alu_result         <= final_result;
            zero_output        <= (final_result == 32'h0);
            overflow           <= ovf_next & in_valid;
            store_data         <= rt_data;
            write_address      <= reg_dst ? rd_field : rt_field;
            register_write     <= dec_reg_write & in_valid;
            memory_read        <= dec_mem_read & in_valid;
            memory_write       <= dec_mem_write & in_valid;
            memory_to_register <= dec_mem_to_reg & in_valid;
            branch_eq          <= dec_branch_eq & in_valid;
            branch_ne          <= dec_branch_ne & in_valid;
            jump               <= dec_jump & in_valid;
        end
    end

endmodule

// File: tb/tb_mips_execute_decode.sv
// Self-checking bench for mips_execute_decode: directed cases plus randomized instructions
// checked against an instruction-level reference model.
module tb_mips_execute_decode;

    logic        system_clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic        out_valid, zero_output, overflow;
    logic [31:0] alu_result, store_data;
    logic [4:0]  write_address;
    logic        register_write, memory_read, memory_write, memory_to_register;
    logic        branch_eq, branch_ne, jump;

    int num_checks = 0;
    int num_pass   = 0;

    mips_execute_decode dut (
        .system_clock       (system_clock),
        .reset              (reset),
        .in_valid           (in_valid),
        .instruction        (instruction),
        .rs_data            (rs_data),
        .rt_data            (rt_data),
        .out_valid          (out_valid),
        .alu_result         (alu_result),
        .zero_output        (zero_output),
        .overflow           (overflow),
        .store_data         (store_data),
        .write_address      (write_address),
        .register_write     (register_write),
        .memory_read        (memory_read),
        .memory_write       (memory_write),
        .memory_to_register (memory_to_register),
        .branch_eq          (branch_eq),
        .branch_ne          (branch_ne),
        .jump               (jump)
    );

    always #5 system_clock = ~system_clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed === expected) num_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Signed overflow judged on the true mathematical result, not on carry bits.
    function automatic logic signed_ovf(input logic [31:0] a, input logic [31:0] b, input logic is_sub);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = is_sub ? sa - sb : sa + sb;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    // Drive one instruction, let the stage capture it, then compare against the reference model.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [5:0]  opc, fn;
        logic [15:0] imm;
        logic [31:0] sx, zx, res;
        logic        res_known, ov, rw, mr, mw, m2r, be, bn, jp;
        opc = ins[31:26]; fn = ins[5:0]; imm = ins[15:0];
        sx = {{16{imm[15]}}, imm}; zx = {16'h0, imm};
        res = 32'h0; res_known = 1'b1; ov = 1'b0;
        rw = 0; mr = 0; mw = 0; m2r = 0; be = 0; bn = 0; jp = 0;
        case (opc)
            6'h00: begin
                rw = 1;
                case (fn)
                    6'h22, 6'h23: res = a - b;
                    6'h24:        res = a & b;
                    6'h25:        res = a | b;
                    6'h27:        res = ~(a | b);
                    6'h2a:        res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default:      res = a + b;
                endcase
                if (fn == 6'h20) ov = signed_ovf(a, b, 1'b0);
                if (fn == 6'h22) ov = signed_ovf(a, b, 1'b1);
            end
            6'h23: begin res = a + sx; mr = 1; m2r = 1; rw = 1; end
            6'h2b: begin res = a + sx; mw = 1; end
            6'h04: begin res = a - b; be = 1; end
            6'h05: begin res = a - b; bn = 1; end
            6'h08: begin res = a + sx; rw = 1; ov = signed_ovf(a, sx, 1'b0); end
            6'h0d: begin res = a | zx; rw = 1; end
            6'h0f: begin res = {imm, 16'h0}; rw = 1; end
            6'h02: begin jp = 1; res_known = 1'b0; end
            default: res_known = 1'b0;
        endcase
`ifndef ALU_OVERFLOW_EN
        ov = 1'b0;
`endif
        @(negedge system_clock);
        in_valid = v; instruction = ins; rs_data = a; rt_data = b;
        @(posedge system_clock);
        #1;
        checkOutput("out_valid", {31'h0, out_valid}, {31'h0, v});
        checkOutput("register_write", {31'h0, register_write}, {31'h0, rw & v});
        checkOutput("memory_read", {31'h0, memory_read}, {31'h0, mr & v});
        checkOutput("memory_write", {31'h0, memory_write}, {31'h0, mw & v});
        checkOutput("branch_eq", {31'h0, branch_eq}, {31'h0, be & v});
        checkOutput("branch_ne", {31'h0, branch_ne}, {31'h0, bn & v});
        checkOutput("jump", {31'h0, jump}, {31'h0, jp & v});
        if (v) begin
            checkOutput("memory_to_register", {31'h0, memory_to_register}, {31'h0, m2r});
            checkOutput("store_data", store_data, b);
            checkOutput("write_address", {27'h0, write_address}, {27'h0, (opc == 6'h00) ? ins[15:11] : ins[20:16]});
            checkOutput("overflow", {31'h0, overflow}, {31'h0, ov});
            if (res_known) begin
                checkOutput("alu_result", alu_result, res);
                checkOutput("zero_output", {31'h0, zero_output}, {31'h0, res == 32'h0});
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
        checkOutput({tag, "_result"}, alu_result, 32'h0);
        checkOutput({tag, "_store"}, store_data, 32'h0);
        checkOutput({tag, "_flags"}, {19'h0, zero_output, overflow, write_address, register_write, memory_read,
                    memory_write, memory_to_register, branch_eq, branch_ne, jump}, 32'h0);
    endtask

    localparam int NUM_OPS = 10;
    logic [5:0] op_list [NUM_OPS] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0d, 6'h0f, 6'h02, 6'h00};
    logic [5:0] fn_list [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a};

    initial begin
        logic [31:0] ins, a, b;
        logic [5:0]  opc;
        #2 reset = 1'b0;
        #1 checkAllZero("reset");
        @(negedge system_clock);
        reset = 1'b1;

        applyStimulus(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7);
        checkOutput("dir_add_result", alu_result, 32'd12);
        checkOutput("dir_add_wa", {27'h0, write_address}, 32'd3);

        applyStimulus(1'b1, itype(6'h04, 5'd1, 5'd2, 16'h0010), 32'h55, 32'h55);
        checkOutput("dir_beq_zero", {31'h0, zero_output}, 32'd1);

        applyStimulus(1'b1, rtype(5'd1, 5'd2, 5'd4, 6'h2a), 32'hFFFF_FFFF, 32'd1);
        checkOutput("dir_slt", alu_result, 32'd1);
        applyStimulus(1'b1, rtype(5'd1, 5'd2, 5'd4, 6'h2a), 32'd1, 32'hFFFF_FFFF);
        checkOutput("dir_slt_swap", alu_result, 32'd0);

        applyStimulus(1'b1, itype(6'h23, 5'd1, 5'd9, 16'hFFFC), 32'h100, 32'h0);
        checkOutput("dir_lw_result", alu_result, 32'hFC);
        checkOutput("dir_lw_wa", {27'h0, write_address}, 32'd9);

        applyStimulus(1'b1, itype(6'h0d, 5'd1, 5'd9, 16'h8001), 32'h1000_0000, 32'h0);
        checkOutput("dir_ori", alu_result, 32'h1000_8001);

        applyStimulus(1'b1, itype(6'h0f, 5'd0, 5'd5, 16'h1234), 32'hDEAD_BEEF, 32'h0);
        checkOutput("dir_lui", alu_result, 32'h1234_0000);

        applyStimulus(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h7FFF_FFFF, 32'd1);
        checkOutput("dir_ovf_result", alu_result, 32'h8000_0000);
`ifdef ALU_OVERFLOW_EN
        checkOutput("dir_ovf_add", {31'h0, overflow}, 32'd1);
`else
        checkOutput("dir_ovf_off", {31'h0, overflow}, 32'd0);
`endif
        applyStimulus(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h21), 32'h7FFF_FFFF, 32'd1);
        checkOutput("dir_addu_noovf", {31'h0, overflow}, 32'd0);

        applyStimulus(1'b0, itype(6'h23, 5'd1, 5'd9, 16'h0004), 32'h1, 32'h2);

        // Asynchronous reset asserted mid-cycle with a valid store in flight.
        applyStimulus(1'b1, itype(6'h2b, 5'd1, 5'd9, 16'h0004), 32'h40, 32'hCAFE);
        #2 reset = 1'b0;
        #1 checkAllZero("async_reset");
        @(posedge system_clock);
        #1 checkAllZero("reset_hold");
        @(negedge system_clock);
        reset = 1'b1;

        for (int i = 0; i < 300; i++) begin
            opc = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_list[$urandom_range(0, NUM_OPS - 1)];
            ins = {opc, 26'($urandom)};
            if (opc == 6'h00)
                ins[5:0] = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 7)];
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            if ($urandom_range(0, 5) == 0) a = {a[31], {31{~a[31]}}};
            applyStimulus($urandom_range(0, 4) != 0, ins, a, b);
        end

        $display("%0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule
